execute_unit: RTL and testbench
===============================

EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter WORD_SIZE, default 32 (`WORD_SIZE), datapath width; SHALL be a power of two >= 8.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_in  input  1  D/E register holds a valid instruction.
REQ-005 instruction_type, pc, opcode, funct7, funct3, s1, s2, immediate  input  2/WORD_SIZE/7/7/3/WORD_SIZE/WORD_SIZE/WORD_SIZE  D/E register outputs.
REQ-006 stall_in  input  1  downstream (E/M) cannot accept.
REQ-007 flush  input  1  kill the instruction at the D/E outputs and any multiply in progress.
REQ-008 stall_out  output  1  drives the D/E register stall; high = hold the D/E register.
REQ-009 valid_out, result_out, store_data_out, funct3_out, instruction_type_out  output  1/WORD_SIZE/WORD_SIZE/3/2  registered E/M payload.
REQ-010 branch_taken_out, target_out  output  1/WORD_SIZE  registered redirect.

Function
REQ-011 Accept: valid_in=1, state IDLE, stall_in=0, flush=0; only then is the instruction consumed.
REQ-012 stall_out SHALL be combinational: 1 when state != IDLE or stall_in=1, else 0.
REQ-013 Single-cycle ops: outputs registered at the accept edge (latency 1); valid_out=1 for that cycle.
REQ-014 OP (0110011, funct7!=0000001): B=s2; OP-IMM (0010011): B=immediate; funct3 000 ADD (SUB if OP and funct7[5]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]), 110 OR, 111 AND.
REQ-015 Shift amount = B[log2(WORD_SIZE)-1:0]; all arithmetic modulo 2^WORD_SIZE, no overflow flag.
REQ-016 LOAD/STORE: result_out=s1+immediate, store_data_out=s2.
REQ-017 BRANCH: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU on s1,s2; target_out=pc+immediate; other funct3 -> not taken.
REQ-018 JAL: result_out=pc+4, target_out=pc+immediate, taken=1; JALR: target_out=(s1+immediate) with bit0 cleared, result_out=pc+4, taken=1.
REQ-019 LUI: result_out=immediate; AUIPC: result_out=pc+immediate.
REQ-020 branch_taken_out SHALL be 0 for every non-branch/jump op; unknown opcode: valid_out=1, result_out=0.
REQ-021 MUL (OP, funct7=0000001): funct3 000 -> low WORD_SIZE bits of s1*s2; other funct3 -> single-cycle, result_out=0.
REQ-022 FSM states IDLE, MUL_BUSY, MUL_DONE; IDLE->MUL_BUSY on accepting MUL (operands latched, counter=0).
REQ-023 MUL_BUSY: one shift-add step per cycle; after WORD_SIZE steps -> MUL_DONE if stall_in=1, else write outputs, valid_out=1, -> IDLE.
REQ-024 MUL_DONE: hold result internally; when stall_in=0 write outputs, valid_out=1, -> IDLE.
REQ-025 Unstalled MUL: valid_out asserted WORD_SIZE edges after accept edge; stall_out high exactly WORD_SIZE cycles.
REQ-026 stall_in=1 in IDLE: no accept, all outputs hold values; valid_out holds.
REQ-027 No accept in IDLE with valid_in=0 and stall_in=0: valid_out=0 next edge, other outputs hold.
REQ-028 flush (priority over stall_in and accept): next edge valid_out=0, branch_taken_out=0, state=IDLE, counter cleared.

Reset
REQ-029 reset has priority over flush; next edge: state IDLE, counter 0, valid_out 0, branch_taken_out 0, result_out, store_data_out, target_out, funct3_out, instruction_type_out all 0.
REQ-030 reset during MUL_BUSY/MUL_DONE SHALL discard the multiply with no valid_out pulse.

Structure
REQ-031 Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), funct7 MULDIV, FSM state enum SHALL live in the shared package.
REQ-032 Iterative multiplier SHALL be a sub-module seq_multiplier (start, operands, done, product) with same clk/reset.

Verification
REQ-033 ADD: OP, s1=5, s2=7, valid_in=1 -> next edge valid_out=1, result_out=12, stall_out=0 throughout.
REQ-034 BLT: s1=0xFFFFFFFF, s2=1, pc=0x100, immediate=0x20 -> branch_taken_out=1, target_out=0x120; BLTU same operands -> taken=0.
REQ-035 MUL: s1=6, s2=0xFFFFFFF9 -> stall_out high 32 cycles, then valid_out=1, result_out=0xFFFFFFD6; following ADD at D/E held until then.
REQ-036 MUL completing with stall_in=1 for 3 cycles -> MUL_DONE held, valid_out=0, result appears on the edge after stall_in falls.
REQ-037 flush at MUL step 10 -> valid_out=0 next edge, stall_out=0, no later result; reset mid-MUL -> all outputs 0.
REQ-038 JALR: s1=0x1003, immediate=0, pc=0x40 -> target_out=0x1002, result_out=0x44, taken=1.

Source files
------------

// File: rtl/execute_unit_pkg.sv
// Shared opcode, funct7 and FSM definitions for the execute stage.
// Imported by execute_unit and its iterative multiplier.
package execute_unit_pkg;

  // Major opcodes (instruction bits [6:0])
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [6:0] MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL = 3'b000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/execute_unit_seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per cycle, low WORD_SIZE bits.
// done/product are valid combinationally during the final step's cycle.
module seq_multiplier #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cancel,
  input  logic                 start,
  input  logic [WORD_SIZE-1:0] op_a,
  input  logic [WORD_SIZE-1:0] op_b,
  output logic                 done,
  output logic [WORD_SIZE-1:0] product
);

  localparam int CW = $clog2(WORD_SIZE) + 1;

  logic [WORD_SIZE-1:0] mcand;
  logic [WORD_SIZE-1:0] mplier;
  logic [WORD_SIZE-1:0] acc;
  logic [WORD_SIZE-1:0] acc_next;
  logic [CW-1:0]        count;
  logic                 busy;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // The last step's sum is exposed directly so the result lands on the step-WORD_SIZE edge.
  assign done     = busy && (count == CW'(WORD_SIZE - 1));
  assign product  = acc_next;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || cancel) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU/branch/jump ops plus an iterative MUL that
// stalls the D/E register until the product is written to the E/M payload.
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [1:0]           instruction_type,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [6:0]           opcode,
  input  logic [6:0]           funct7,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] s1,
  input  logic [WORD_SIZE-1:0] s2,
  input  logic [WORD_SIZE-1:0] immediate,
  input  logic                 stall_in,
  input  logic                 flush,
  output logic                 stall_out,
  output logic                 valid_out,
  output logic [WORD_SIZE-1:0] result_out,
  output logic [WORD_SIZE-1:0] store_data_out,
  output logic [2:0]           funct3_out,
  output logic [1:0]           instruction_type_out,
  output logic                 branch_taken_out,
  output logic [WORD_SIZE-1:0] target_out
);

  localparam int SHW = $clog2(WORD_SIZE);

  state_t               state;
  logic                 accept;
  logic                 is_mul;
  logic                 mul_done;
  logic [WORD_SIZE-1:0] mul_product;
  logic [WORD_SIZE-1:0] mul_result;
  logic [2:0]           mul_funct3;
  logic [1:0]           mul_type;

  logic [WORD_SIZE-1:0] alu_b;
  logic [SHW-1:0]       shamt;
  logic [WORD_SIZE-1:0] jalr_sum;
  logic                 br_cond;
  logic [WORD_SIZE-1:0] ex_result;
  logic [WORD_SIZE-1:0] ex_store;
  logic [WORD_SIZE-1:0] ex_target;
  logic                 ex_taken;

  assign stall_out = (state != IDLE) || stall_in;
  assign accept    = valid_in && (state == IDLE) && !stall_in && !flush;
  assign is_mul    = (opcode == OP) && (funct7 == MULDIV) && (funct3 == F3_MUL);

  assign alu_b    = (opcode == OP) ? s2 : immediate;
  assign shamt    = alu_b[SHW-1:0];
  assign jalr_sum = s1 + immediate;

  always_comb begin
    br_cond = 1'b0;
    unique case (funct3)
      3'b000:  br_cond = (s1 == s2);
      3'b001:  br_cond = (s1 != s2);
      3'b100:  br_cond = ($signed(s1) <  $signed(s2));
      3'b101:  br_cond = ($signed(s1) >= $signed(s2));
      3'b110:  br_cond = (s1 <  s2);
      3'b111:  br_cond = (s1 >= s2);
      default: br_cond = 1'b0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ex_result = '0;
    ex_store  = '0;
    ex_target = '0;
    ex_taken  = 1'b0;
    case (opcode)
      OP, OP_IMM: begin
        // MUL with funct3 000 is owned by the FSM; other M-ops retire as zero.
        if (!((opcode == OP) && (funct7 == MULDIV))) begin
          unique case (funct3)
            3'b000: ex_result = ((opcode == OP) && funct7[5]) ? s1 - alu_b : s1 + alu_b;
            3'b001: ex_result = s1 << shamt;
            3'b010: ex_result = {{(WORD_SIZE-1){1'b0}}, $signed(s1) < $signed(alu_b)};
            3'b011: ex_result = {{(WORD_SIZE-1){1'b0}}, s1 < alu_b};
            3'b100: ex_result = s1 ^ alu_b;
            3'b101: ex_result = funct7[5] ? WORD_SIZE'($signed(s1) >>> shamt) : s1 >> shamt;
            3'b110: ex_result = s1 | alu_b;
            3'b111: ex_result = s1 & alu_b;
            default: ex_result = '0;
          endcase
        end
      end
      LOAD, STORE: begin
        ex_result = s1 + immediate;
        ex_store  = s2;
      end
      BRANCH: begin
        ex_target = pc + immediate;
        ex_taken  = br_cond;
      end
      JAL: begin
        ex_result = pc + WORD_SIZE'(4);
        ex_target = pc + immediate;
        ex_taken  = 1'b1;
      end
      JALR: begin
        ex_result = pc + WORD_SIZE'(4);
        ex_target = {jalr_sum[WORD_SIZE-1:1], 1'b0};
        ex_taken  = 1'b1;
      end
      LUI:     ex_result = immediate;
      AUIPC:   ex_result = pc + immediate;
      default: ex_result = '0;
    endcase
  end

  seq_multiplier #(.WORD_SIZE(WORD_SIZE)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .cancel  (flush),
    .start   (accept && is_mul),
    .op_a    (s1),
    .op_b    (s2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      valid_out            <= 1'b0;
      result_out           <= '0;
      store_data_out       <= '0;
      funct3_out           <= '0;
      instruction_type_out <= '0;
      branch_taken_out     <= 1'b0;
      target_out           <= '0;
      mul_result           <= '0;
      mul_funct3           <= '0;
      mul_type             <= '0;
    end else if (flush) begin
      state            <= IDLE;
      valid_out        <= 1'b0;
      branch_taken_out <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state            <= MUL_BUSY;
            valid_out        <= 1'b0;
            branch_taken_out <= 1'b0;
            mul_funct3       <= funct3;
            mul_type         <= instruction_type;
          end else if (accept) begin
            valid_out            <= 1'b1;
            result_out           <= ex_result;
            store_data_out       <= ex_store;
            funct3_out           <= funct3;
            instruction_type_out <= instruction_type;
            branch_taken_out     <= ex_taken;
            target_out           <= ex_target;
          end else if (!stall_in) begin
            valid_out <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            if (stall_in) begin
              state      <= MUL_DONE;
              mul_result <= mul_product;
            end else begin
              state                <= IDLE;
              valid_out            <= 1'b1;
              result_out           <= mul_product;
              store_data_out       <= '0;
              funct3_out           <= mul_funct3;
              instruction_type_out <= mul_type;
              branch_taken_out     <= 1'b0;
              target_out           <= '0;
            end
          end
        end
        MUL_DONE: begin
          if (!stall_in) begin
            state                <= IDLE;
            valid_out            <= 1'b1;
            result_out           <= mul_result;
            store_data_out       <= '0;
            funct3_out           <= mul_funct3;
            instruction_type_out <= mul_type;
            branch_taken_out     <= 1'b0;
            target_out           <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_unit.sv
// Directed self-checking bench for execute_unit (WORD_SIZE = 32).
module tb_execute_unit;
  import execute_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [1:0]   instruction_type;
  logic [W-1:0] pc;
  logic [6:0]   opcode;
  logic [6:0]   funct7;
  logic [2:0]   funct3;
  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic [W-1:0] immediate;
  logic         stall_in;
  logic         flush;
  logic         stall_out;
  logic         valid_out;
  logic [W-1:0] result_out;
  logic [W-1:0] store_data_out;
  logic [2:0]   funct3_out;
  logic [1:0]   instruction_type_out;
  logic         branch_taken_out;
  logic [W-1:0] target_out;

  int n_checks = 0;
  int n_pass   = 0;

  execute_unit #(.WORD_SIZE(W)) dut (
    .clk                  (clk),
    .reset                (reset),
    .valid_in             (valid_in),
    .instruction_type     (instruction_type),
    .pc                   (pc),
    .opcode               (opcode),
    .funct7               (funct7),
    .funct3               (funct3),
    .s1                   (s1),
    .s2                   (s2),
    .immediate            (immediate),
    .stall_in             (stall_in),
    .flush                (flush),
    .stall_out            (stall_out),
    .valid_out            (valid_out),
    .result_out           (result_out),
    .store_data_out       (store_data_out),
    .funct3_out           (funct3_out),
    .instruction_type_out (instruction_type_out),
    .branch_taken_out     (branch_taken_out),
    .target_out           (target_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic [W-1:0] p);
    valid_in  = 1'b1;
    opcode    = op;
    funct7    = f7;
    funct3    = f3;
    s1        = a;
    s2        = b;
    immediate = imm;
    pc        = p;
  endtask

  initial begin
    int n;
    int pulses;
    reset = 1'b1; valid_in = 1'b0; instruction_type = 2'd0; pc = '0;
    opcode = '0; funct7 = '0; funct3 = '0; s1 = '0; s2 = '0; immediate = '0;
    stall_in = 1'b0; flush = 1'b0;
    tick(); tick();
    check("rst_valid", valid_out, 0);
    check("rst_result", result_out, 0);
    check("rst_taken", branch_taken_out, 0);
    check("rst_target", target_out, 0);
    check("rst_store", store_data_out, 0);
    check("rst_f3", funct3_out, 0);
    check("rst_type", instruction_type_out, 0);
    reset = 1'b0;
    check("rst_stall", stall_out, 0);

    // ADD 5+7
    instruction_type = 2'd1;
    drive(OP, 7'h00, 3'b000, 5, 7, 0, 0);
    #1 check("add_stall_pre", stall_out, 0);
    tick();
    check("add_valid", valid_out, 1);
    check("add_result", result_out, 12);
    check("add_stall", stall_out, 0);
    check("add_type", instruction_type_out, 1);
    instruction_type = 2'd0;

    drive(OP, 7'h20, 3'b000, 5, 7, 0, 0); tick();
    check("sub", result_out, 32'hFFFF_FFFE);
    drive(OP_IMM, 7'h20, 3'b101, 32'h8000_0000, 0, 32'h0000_0404, 0); tick();
    check("srai_mask", result_out, 32'hF800_0000);
    check("srai_f3", funct3_out, 3'b101);
    drive(OP, 7'h00, 3'b010, 32'hFFFF_FFFF, 1, 0, 0); tick();
    check("slt", result_out, 1);
    drive(OP_IMM, 7'h00, 3'b011, 32'hFFFF_FFFF, 0, 1, 0); tick();
    check("sltiu", result_out, 0);

    drive(BRANCH, 7'h00, 3'b100, 32'hFFFF_FFFF, 1, 32'h20, 32'h100); tick();
    check("blt_taken", branch_taken_out, 1);
    check("blt_target", target_out, 32'h120);
    drive(BRANCH, 7'h00, 3'b110, 32'hFFFF_FFFF, 1, 32'h20, 32'h100); tick();
    check("bltu_taken", branch_taken_out, 0);
    check("bltu_target", target_out, 32'h120);
    drive(BRANCH, 7'h00, 3'b010, 3, 3, 32'h20, 32'h100); tick();
    check("bres_taken", branch_taken_out, 0);

    drive(JALR, 7'h00, 3'b000, 32'h1003, 0, 0, 32'h40); tick();
    check("jalr_target", target_out, 32'h1002);
    check("jalr_result", result_out, 32'h44);
    check("jalr_taken", branch_taken_out, 1);
    drive(LUI, 7'h00, 3'b000, 0, 0, 32'h1234_5000, 0); tick();
    check("lui_result", result_out, 32'h1234_5000);
    check("lui_taken", branch_taken_out, 0);
    drive(STORE, 7'h00, 3'b010, 32'h100, 32'hDEAD, 32'hFFFF_FFFC, 0); tick();
    check("sw_addr", result_out, 32'hFC);
    check("sw_data", store_data_out, 32'hDEAD);
    drive(7'b0000000, 7'h00, 3'b000, 9, 9, 9, 0); tick();
    check("unk_valid", valid_out, 1);
    check("unk_result", result_out, 0);

    // stall_in in IDLE: nothing consumed, outputs hold
    drive(OP, 7'h00, 3'b000, 1, 1, 0, 0);
    stall_in = 1'b1;
    #1 check("hold_stall_out", stall_out, 1);
    tick();
    check("hold_valid", valid_out, 1);
    check("hold_result", result_out, 0);
    stall_in = 1'b0; valid_in = 1'b0; tick();
    check("idle_valid", valid_out, 0);
    check("idle_result", result_out, 0);

    // Unstalled MUL followed by an ADD waiting at D/E
    drive(OP, MULDIV, 3'b000, 6, 32'hFFFF_FFF9, 0, 0); tick();
    drive(OP, 7'h00, 3'b000, 1, 2, 0, 0);
    n = 0;
    while (stall_out && n < 100) begin
      n++;
      if (n == 5) check("mul_busy_valid", valid_out, 0);
      tick();
    end
    check("mul_stall_cycles", n, 32);
    check("mul_valid", valid_out, 1);
    check("mul_result", result_out, 32'hFFFF_FFD6);
    tick();
    check("after_mul_add", result_out, 3);
    check("after_mul_valid", valid_out, 1);

    // MUL finishing under stall_in for 3 cycles
    drive(OP, MULDIV, 3'b000, 3, 5, 0, 0); tick();
    valid_in = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    stall_in = 1'b1;
    tick();
    check("muld_valid0", valid_out, 0);
    check("muld_stall", stall_out, 1);
    tick(); tick();
    check("muld_valid2", valid_out, 0);
    check("muld_result_hold", result_out, 3);
    stall_in = 1'b0;
    tick();
    check("muld_valid", valid_out, 1);
    check("muld_result", result_out, 15);
    tick();
    check("muld_pulse_end", valid_out, 0);

    // Flush at step 10
    drive(OP, MULDIV, 3'b000, 6, 7, 0, 0); tick();
    valid_in = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_valid", valid_out, 0);
    check("flush_stall", stall_out, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (valid_out) pulses++; end
    check("flush_no_result", pulses, 0);

    // Flush in IDLE kills the D/E instruction
    drive(OP, 7'h00, 3'b000, 4, 4, 0, 0);
    flush = 1'b1; tick(); flush = 1'b0; valid_in = 1'b0;
    check("flush_idle_valid", valid_out, 0);
    check("flush_idle_result", result_out, 15);

    // Reset mid-MUL
    drive(OP, MULDIV, 3'b000, 6, 7, 0, 0); tick();
    valid_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rmul_valid", valid_out, 0);
    check("rmul_result", result_out, 0);
    check("rmul_f3", funct3_out, 0);
    check("rmul_stall", stall_out, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (valid_out) pulses++; end
    check("rmul_no_result", pulses, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
